multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter SUPPORT_JAL, default 1, meaning: 1 decodes JAL (opcode 111); 0 treats 111 as illegal.
REQ-002 Parameter MEM_HANDSHAKE, default 1, meaning: 1 stalls memory states on mem_ready; 0 ties mem_ready internally to 1.
REQ-003 Parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-004 clk_i  input  1  single clock, all state updates on the rising edge.
REQ-005 arst_ni  input  1  reset, asynchronous and active-low.
REQ-006 instr_type  input  instr_type_t (7-bit opcode)  opcode of the latched instruction.
REQ-007 func_code  input  func_code_t (3)  funct3.
REQ-008 funct7b5  input  1  instruction bit 30.
REQ-009 zero  input  1  ALU zero flag.
REQ-010 mem_ready  input  1  memory completes the current access this cycle.
REQ-011 mem_req  output  1  memory access request.
REQ-012 pcwrite, adrsrc, irwrite, memwrite, regwrite  output  1 each  datapath enables and selects.
REQ-013 resultsrc, alusrc_a, alusrc_b, immsrc  output  2 each  datapath selects.
REQ-014 alu_ctrl  output  alu_op_t  ALU operation.
REQ-015 illegal_o  output  1  one-cycle pulse on an undecodable opcode.
REQ-016 instret_o  output  CNT_W  count of retired instructions.

Function
REQ-017 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL; Moore outputs, except that pcwrite, irwrite and the instret increment are gated by zero and mem_ready as stated below.
REQ-018 FETCH: mem_req=1, adrsrc=0, alusrc_a=00, alusrc_b=10, alu_ctrl=ADD_OP, resultsrc=10; irwrite=pcwrite=mem_ready; FETCH holds while mem_ready=0, otherwise advances to DECODE.
REQ-019 DECODE: alusrc_a=01, alusrc_b=01, alu_ctrl=ADD_OP; next state by opcode: 3 or 35 -> MEMADR, 51 -> EXECUTER, 19 -> EXECUTEI, 99 -> BEQ, 111 -> JAL (only if SUPPORT_JAL=1), any other -> ILLEGAL.
REQ-020 MEMADR: alusrc_a=10, alusrc_b=01, ADD_OP; next state MEMREAD if opcode 3, else MEMWRITE.
REQ-021 MEMREAD: mem_req=1, adrsrc=1, resultsrc=00; holds until mem_ready, then goes to MEMWB.
REQ-022 MEMWB: resultsrc=01, regwrite=1; next state FETCH.
REQ-023 MEMWRITE: mem_req=1, adrsrc=1, memwrite=1; holds until mem_ready, then goes to FETCH.
REQ-024 EXECUTER: alusrc_a=10, alusrc_b=00, ALU decode; next state ALUWB.
REQ-025 EXECUTEI: alusrc_a=10, alusrc_b=01, ALU decode; next state ALUWB.
REQ-026 ALUWB: resultsrc=00, regwrite=1; next state FETCH.
REQ-027 BEQ: alusrc_a=10, alusrc_b=00, alu_ctrl=BEQ_OP, resultsrc=00, pcwrite=zero; next state FETCH.
REQ-028 JAL: alusrc_a=01, alusrc_b=10, ADD_OP, resultsrc=00, pcwrite=1; next state ALUWB.
REQ-029 ILLEGAL: illegal_o=1 for exactly that one cycle, no write enables asserted; next state FETCH.
REQ-030 In every state, any output not listed for that state is 0, and mem_req, memwrite, regwrite and irwrite are never asserted outside the states named above.
REQ-031 immsrc is combinational from opcode: 3/19 -> 00, 35 -> 01, 99 -> 10, 111 -> 11, otherwise 00.
REQ-032 ALU decode, by func_code: 0 -> SUB_OP when opcode 51 and funct7b5=1, otherwise ADD_OP; 1 -> SLL_OP; 4 -> XOR_OP; 5 -> SRA_OP when funct7b5=1, otherwise SRL_OP; 6 -> OR_OP; 7 -> AND_OP; 2 and 3 -> ADD_OP.
REQ-033 instret_o increments by 1 on the last cycle of each instruction (MEMWB, ALUWB, BEQ, and MEMWRITE when mem_ready=1); it wraps modulo 2^CNT_W; ILLEGAL does not increment it.
REQ-034 When MEM_HANDSHAKE=0, every memory state lasts exactly 1 cycle.
REQ-035 Instruction latency with mem_ready always 1: load 5 cycles, store 4, R/I ALU 4, BEQ 3, JAL 4.

Reset
REQ-036 While arst_ni=0: state=FETCH, instret_o=0, illegal_o=0; all other outputs take their FETCH values with mem_ready gating applied.
REQ-037 Reset asserted mid-instruction aborts it immediately; the first rising edge after release evaluates FETCH.

Verification
REQ-038 mem_ready=1; issue add (51, f3=0, b5=0) then sub (b5=1) -> FETCH, DECODE, EXECUTER, ALUWB; alu_ctrl ADD_OP then SUB_OP; instret_o=2.
REQ-039 lw (opcode 3); mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_req=1 and adrsrc=1 throughout, single regwrite pulse in MEMWB.
REQ-040 beq (opcode 99) with zero=1, then with zero=0 -> pcwrite=1 in BEQ, then 0; immsrc=10; instret_o increments in both cases.
REQ-041 Opcode 111 with SUPPORT_JAL=0 -> one-cycle illegal_o pulse, return to FETCH, instret_o unchanged; with SUPPORT_JAL=1 -> JAL then ALUWB, pcwrite=1.
REQ-042 Assert arst_ni=0 during MEMWRITE -> memwrite drops asynchronously and instret_o=0; CNT_W=4 with 16 retirements -> instret_o wraps to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode,
// memory, ALU and branch steps, plus a retired-instruction counter.
package multicycle_control_unit_pkg;
    typedef logic [6:0] instr_type_t;
    typedef logic [2:0] func_code_t;

    typedef enum logic [3:0] {
        ADD_OP = 4'd0,
        SUB_OP = 4'd1,
        AND_OP = 4'd2,
        OR_OP  = 4'd3,
        XOR_OP = 4'd4,
        SLL_OP = 4'd5,
        SRL_OP = 4'd6,
        SRA_OP = 4'd7,
        BEQ_OP = 4'd8
    } alu_op_t;

    localparam instr_type_t OP_LOAD  = 7'd3;
    localparam instr_type_t OP_ITYPE = 7'd19;
    localparam instr_type_t OP_STORE = 7'd35;
    localparam instr_type_t OP_RTYPE = 7'd51;
    localparam instr_type_t OP_BEQ   = 7'd99;
    localparam instr_type_t OP_JAL   = 7'd111;
endpackage

module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int SUPPORT_JAL   = 1,
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  instr_type_t      instr_type,
    input  func_code_t       func_code,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       immsrc,
    output alu_op_t          alu_ctrl,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
    } state_t;

    state_t  state, next;
    logic    rdy;
    logic    retire;
    alu_op_t alu_dec;

    assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state     <= FETCH;
            instret_o <= '0;
        end else begin
            state <= next;
            if (retire)
                instret_o <= instret_o + CNT_W'(1);
        end
    end

    always_comb begin
        unique case (func_code)
            3'd0: alu_dec = (instr_type == OP_RTYPE && funct7b5)
                            ? SUB_OP : ADD_OP;
            3'd1: alu_dec = SLL_OP;
            3'd2: alu_dec = ADD_OP;
            3'd3: alu_dec = ADD_OP;
            3'd4: alu_dec = XOR_OP;
            3'd5: alu_dec = funct7b5 ? SRA_OP : SRL_OP;
            3'd6: alu_dec = OR_OP;
            3'd7: alu_dec = AND_OP;
        endcase
    end

    always_comb begin
        case (instr_type)
            OP_LOAD, OP_ITYPE: immsrc = 2'b00;
            OP_STORE:          immsrc = 2'b01;
            OP_BEQ:            immsrc = 2'b10;
            OP_JAL:            immsrc = 2'b11;
            default:           immsrc = 2'b00;
        endcase
    end

    always_comb begin
        next      = state;
        mem_req   = 1'b0;
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 2'b00;
        alusrc_a  = 2'b00;
        alusrc_b  = 2'b00;
        alu_ctrl  = ADD_OP;
        illegal_o = 1'b0;
        retire    = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alusrc_b  = 2'b10;
                resultsrc = 2'b10;
                irwrite   = rdy;
                pcwrite   = rdy;
                if (rdy)
                    next = DECODE;
            end
            DECODE: begin
                alusrc_a = 2'b01;
                alusrc_b = 2'b01;
                case (instr_type)
                    OP_LOAD, OP_STORE: next = MEMADR;
                    OP_RTYPE:          next = EXECUTER;
                    OP_ITYPE:          next = EXECUTEI;
                    OP_BEQ:            next = BEQ;
                    OP_JAL:            next = (SUPPORT_JAL != 0) ? JAL : ILLEGAL;
                    default:           next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alusrc_a = 2'b10;
                alusrc_b = 2'b01;
                next     = (instr_type == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                if (rdy)
                    next = MEMWB;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                retire    = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = rdy;
                if (rdy)
                    next = FETCH;
            end
            EXECUTER: begin
                alusrc_a = 2'b10;
                alu_ctrl = alu_dec;
                next     = ALUWB;
            end
            EXECUTEI: begin
                alusrc_a = 2'b10;
                alusrc_b = 2'b01;
                alu_ctrl = alu_dec;
                next     = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                next     = FETCH;
            end
            BEQ: begin
                alusrc_a = 2'b10;
                alu_ctrl = BEQ_OP;
                pcwrite  = zero;
                retire   = 1'b1;
                next     = FETCH;
            end
            JAL: begin
                alusrc_a = 2'b01;
                alusrc_b = 2'b10;
                pcwrite  = 1'b1;
                next     = ALUWB;
            end
            ILLEGAL: begin
                illegal_o = 1'b1;
                next      = FETCH;
            end
            default: next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default build plus a
// no-JAL, no-handshake, 4-bit counter build.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3;
    localparam int S_MEMWB = 4, S_MEMWRITE = 5, S_EXR = 6, S_EXI = 7;
    localparam int S_ALUWB = 8, S_BEQ = 9, S_JAL = 10, S_ILL = 11;

    logic clk = 1'b0;
    logic arst_ni;
    always #5 clk = ~clk;

    instr_type_t op, op2;
    func_code_t  f3, f32;
    logic        b5, b52, zero, zero2, rdy, rdy2;

    logic        mem_req1, pcw1, adr1, irw1, memw1, regw1, ill1;
    logic [1:0]  rs1, sa1, sb1, imm1;
    alu_op_t     alu1;
    logic [31:0] instret1;

    logic        mem_req2, pcw2, adr2, irw2, memw2, regw2, ill2;
    logic [1:0]  rs2, sa2, sb2, imm2;
    alu_op_t     alu2;
    logic [3:0]  instret2;

    logic [16:0] obs1, obs2;
    assign obs1 = {mem_req1, pcw1, adr1, irw1, memw1, regw1,
                   rs1, sa1, sb1, alu1, ill1};
    assign obs2 = {mem_req2, pcw2, adr2, irw2, memw2, regw2,
                   rs2, sa2, sb2, alu2, ill2};

    multicycle_control_unit dut (
        .clk_i(clk), .arst_ni(arst_ni), .instr_type(op),
        .func_code(f3), .funct7b5(b5), .zero(zero),
        .mem_ready(rdy), .mem_req(mem_req1), .pcwrite(pcw1),
        .adrsrc(adr1), .irwrite(irw1), .memwrite(memw1),
        .regwrite(regw1), .resultsrc(rs1), .alusrc_a(sa1),
        .alusrc_b(sb1), .immsrc(imm1), .alu_ctrl(alu1),
        .illegal_o(ill1), .instret_o(instret1)
    );

    multicycle_control_unit #(
        .SUPPORT_JAL(0), .MEM_HANDSHAKE(0), .CNT_W(4)
    ) dut2 (
        .clk_i(clk), .arst_ni(arst_ni), .instr_type(op2),
        .func_code(f32), .funct7b5(b52), .zero(zero2),
        .mem_ready(rdy2), .mem_req(mem_req2), .pcwrite(pcw2),
        .adrsrc(adr2), .irwrite(irw2), .memwrite(memw2),
        .regwrite(regw2), .resultsrc(rs2), .alusrc_a(sa2),
        .alusrc_b(sb2), .immsrc(imm2), .alu_ctrl(alu2),
        .illegal_o(ill2), .instret_o(instret2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Hand-written output table per state.
    function automatic logic [16:0] ev(input int st, input alu_op_t alu,
                                       input logic g);
        logic mr, pw, ad, iw, mw, rw, il;
        logic [1:0] rs, sa, sb;
        alu_op_t o;
        {mr, pw, ad, iw, mw, rw, il} = 7'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; o = ADD_OP;
        case (st)
            S_FETCH:    begin mr = 1; pw = g; iw = g; rs = 2; sb = 2; end
            S_DECODE:   begin sa = 1; sb = 1; end
            S_MEMADR:   begin sa = 2; sb = 1; end
            S_MEMREAD:  begin mr = 1; ad = 1; end
            S_MEMWB:    begin rs = 1; rw = 1; end
            S_MEMWRITE: begin mr = 1; ad = 1; mw = 1; end
            S_EXR:      begin sa = 2; o = alu; end
            S_EXI:      begin sa = 2; sb = 1; o = alu; end
            S_ALUWB:    begin rw = 1; end
            S_BEQ:      begin sa = 2; o = BEQ_OP; pw = g; end
            S_JAL:      begin sa = 1; sb = 2; pw = 1; end
            S_ILL:      begin il = 1; end
            default:    ;
        endcase
        return {mr, pw, ad, iw, mw, rw, rs, sa, sb, o, il};
    endfunction

    task automatic expect_st(input bit which, input string tag, input int st,
                             input alu_op_t alu, input logic g);
        chk(tag, {15'd0, which ? obs2 : obs1}, {15'd0, ev(st, alu, g)});
    endtask

    task automatic cyc(input bit which, input string tag, input int st,
                       input alu_op_t alu, input logic g);
        expect_st(which, tag, st, alu, g);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input string tag, input int ex,
                             input alu_op_t alu, input logic [31:0] cnt);
        cyc(0, {tag, "_f"}, S_FETCH, ADD_OP, 1);
        cyc(0, {tag, "_d"}, S_DECODE, ADD_OP, 0);
        cyc(0, {tag, "_x"}, ex, alu, 0);
        cyc(0, {tag, "_wb"}, S_ALUWB, ADD_OP, 0);
        chk({tag, "_cnt"}, instret1, cnt);
    endtask

    initial begin
        arst_ni = 0; rdy = 1; op = 7'd51; f3 = 0; b5 = 0; zero = 0;
        op2 = 7'd51; f32 = 0; b52 = 0; zero2 = 0; rdy2 = 0;
        #12;
        expect_st(0, "rst_outs", S_FETCH, ADD_OP, 1);
        chk("rst_cnt", instret1, 0);
        rdy = 0; #1;
        expect_st(0, "rst_gate", S_FETCH, ADD_OP, 0);
        rdy = 1;
        @(negedge clk); arst_ni = 1; #1;

        alu_instr("add", S_EXR, ADD_OP, 1);
        b5 = 1;
        alu_instr("sub", S_EXR, SUB_OP, 2);

        op = 7'd3; b5 = 0;
        cyc(0, "lw_f", S_FETCH, ADD_OP, 1);
        cyc(0, "lw_d", S_DECODE, ADD_OP, 0);
        chk("lw_imm", {30'd0, imm1}, 0);
        cyc(0, "lw_a", S_MEMADR, ADD_OP, 0);
        rdy = 0;
        repeat (3) cyc(0, "lw_wait", S_MEMREAD, ADD_OP, 0);
        rdy = 1;
        cyc(0, "lw_rd", S_MEMREAD, ADD_OP, 0);
        cyc(0, "lw_wb", S_MEMWB, ADD_OP, 0);
        chk("lw_cnt", instret1, 3);

        op = 7'd35;
        cyc(0, "sw_f", S_FETCH, ADD_OP, 1);
        chk("sw_imm", {30'd0, imm1}, 1);
        cyc(0, "sw_d", S_DECODE, ADD_OP, 0);
        cyc(0, "sw_a", S_MEMADR, ADD_OP, 0);
        rdy = 0;
        cyc(0, "sw_wait", S_MEMWRITE, ADD_OP, 0);
        chk("sw_cnt_hold", instret1, 3);
        rdy = 1;
        cyc(0, "sw_wr", S_MEMWRITE, ADD_OP, 0);
        chk("sw_cnt", instret1, 4);

        op = 7'd99; zero = 1;
        cyc(0, "beq1_f", S_FETCH, ADD_OP, 1);
        cyc(0, "beq1_d", S_DECODE, ADD_OP, 0);
        chk("beq_imm", {30'd0, imm1}, 2);
        cyc(0, "beq1_b", S_BEQ, ADD_OP, 1);
        chk("beq1_cnt", instret1, 5);
        zero = 0;
        cyc(0, "beq0_f", S_FETCH, ADD_OP, 1);
        cyc(0, "beq0_d", S_DECODE, ADD_OP, 0);
        cyc(0, "beq0_b", S_BEQ, ADD_OP, 0);
        chk("beq0_cnt", instret1, 6);

        op = 7'd111;
        cyc(0, "jal_f", S_FETCH, ADD_OP, 1);
        cyc(0, "jal_d", S_DECODE, ADD_OP, 0);
        chk("jal_imm", {30'd0, imm1}, 3);
        cyc(0, "jal_j", S_JAL, ADD_OP, 0);
        cyc(0, "jal_wb", S_ALUWB, ADD_OP, 0);
        chk("jal_cnt", instret1, 7);

        op = 7'd19; f3 = 4;
        alu_instr("xori", S_EXI, XOR_OP, 8);
        f3 = 5; b5 = 1;
        alu_instr("srai", S_EXI, SRA_OP, 9);
        f3 = 0;
        alu_instr("addi_b5", S_EXI, ADD_OP, 10);
        op = 7'd51; f3 = 7; b5 = 0;
        alu_instr("and", S_EXR, AND_OP, 11);

        op = 7'd35; f3 = 0;
        cyc(0, "swr_f", S_FETCH, ADD_OP, 1);
        cyc(0, "swr_d", S_DECODE, ADD_OP, 0);
        cyc(0, "swr_a", S_MEMADR, ADD_OP, 0);
        expect_st(0, "swr_w", S_MEMWRITE, ADD_OP, 0);
        #2 arst_ni = 0;
        #1;
        chk("rst_memwrite", {31'd0, memw1}, 0);
        chk("rst_cnt2", instret1, 0);
        expect_st(0, "rst_fetch", S_FETCH, ADD_OP, 1);
        @(negedge clk); arst_ni = 1; #1;

        op2 = 7'd111;
        cyc(1, "nj_f", S_FETCH, ADD_OP, 1);
        cyc(1, "nj_d", S_DECODE, ADD_OP, 0);
        cyc(1, "nj_ill", S_ILL, ADD_OP, 0);
        chk("nj_cnt", {28'd0, instret2}, 0);
        op2 = 7'd3;
        for (int i = 0; i < 16; i++) begin
            cyc(1, "w_f", S_FETCH, ADD_OP, 1);
            cyc(1, "w_d", S_DECODE, ADD_OP, 0);
            cyc(1, "w_a", S_MEMADR, ADD_OP, 0);
            cyc(1, "w_rd", S_MEMREAD, ADD_OP, 0);
            cyc(1, "w_wb", S_MEMWB, ADD_OP, 0);
            if (i == 14)
                chk("wrap_15", {28'd0, instret2}, 15);
        end
        chk("wrap_0", {28'd0, instret2}, 0);
        expect_st(1, "wrap_f", S_FETCH, ADD_OP, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
